// File: rtl/grf_multiport_pkg.sv
// Shared constants for the multiport register file: default geometry and trace PC width.
package grf_multiport_pkg;
  localparam int GRF_DATA_W = 32;
  localparam int GRF_ADDR_W = 5;
  localparam int GRF_PC_W   = 32;
endpackage

// File: rtl/grf_read_port.sv
// One combinational read port: storage mux, optional same-cycle write forwarding, pending lookup.
module grf_read_port
  import grf_multiport_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0]              rd_addr,
  input  logic [(2**ADDR_W)*DATA_W-1:0]  rf_flat,
  input  logic [(2**ADDR_W)-1:0]         pend_vec,
  input  logic [NWR-1:0]                 wr_act,
  input  logic [NWR*ADDR_W-1:0]          wa,
  input  logic [NWR*DATA_W-1:0]          wd,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           rd_pend
);

  always_comb begin
    rd_data = rf_flat[int'(rd_addr)*DATA_W +: DATA_W];
    // Later ports override earlier ones so the highest write port wins the forward.
    if (BYPASS != 0) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_act[j] && (wa[j*ADDR_W +: ADDR_W] == rd_addr)) begin
          rd_data = wd[j*DATA_W +: DATA_W];
        end
      end
    end
    // Pending is the registered state only; a same-cycle write does not hide it.
    rd_pend = pend_vec[rd_addr];
  end

endmodule

// File: rtl/grf_multiport.sv
// Multi-ported register file with issue scoreboard and a registered write trace.
// Register 0 is hardwired to zero, never pending and never traced.
module grf_multiport
  import grf_multiport_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NRD*ADDR_W-1:0]    rd_addr,
  output logic [NRD*DATA_W-1:0]    rd_data,
  output logic [NRD-1:0]           rd_pend,
  input  logic [NWR-1:0]           we,
  input  logic [NWR*ADDR_W-1:0]    wa,
  input  logic [NWR*DATA_W-1:0]    wd,
  input  logic [NWR*GRF_PC_W-1:0]  wpc,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NWR-1:0]           tr_valid,
  output logic [NWR*ADDR_W-1:0]    tr_addr,
  output logic [NWR*DATA_W-1:0]    tr_data,
  output logic [NWR*GRF_PC_W-1:0]  tr_pc
);

  localparam int DEPTH = 2**ADDR_W;

  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("grf_multiport: NRD must be in 1..4");
  end
  if (NWR < 1 || NWR > 2) begin : g_bad_nwr
    $error("grf_multiport: NWR must be in 1..2");
  end
  if (BYPASS != 0 && BYPASS != 1) begin : g_bad_bypass
    $error("grf_multiport: BYPASS must be 0 or 1");
  end
  if (DATA_W < 1 || ADDR_W < 1) begin : g_bad_width
    $error("grf_multiport: DATA_W and ADDR_W must be positive");
  end

  logic [DATA_W-1:0]         rf_q [DEPTH];
  logic [DATA_W-1:0]         rf_d [DEPTH];
  logic [DEPTH-1:0]          pend_q, pend_d;
  logic [NWR-1:0]            tr_valid_q, tr_valid_d;
  logic [NWR*ADDR_W-1:0]     tr_addr_q, tr_addr_d;
  logic [NWR*DATA_W-1:0]     tr_data_q, tr_data_d;
  logic [NWR*GRF_PC_W-1:0]   tr_pc_q, tr_pc_d;
  logic [NWR-1:0]            wr_act;
  logic [DEPTH*DATA_W-1:0]   rf_flat;

  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      wr_act[j] = we[j] && (wa[j*ADDR_W +: ADDR_W] != '0);
    end
  end

  // Ports are applied in ascending order so port 1 wins a same-address collision.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rf_d[i] = rf_q[i];
    end
    for (int j = 0; j < NWR; j++) begin
      if (wr_act[j]) begin
        rf_d[wa[j*ADDR_W +: ADDR_W]] = wd[j*DATA_W +: DATA_W];
      end
    end
    rf_d[0] = '0;
  end

  // Clear first, then set, so an issue overrides a retiring write to the same register.
  always_comb begin
    pend_d = pend_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_act[j]) begin
        pend_d[wa[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (iss_valid && (iss_addr != '0)) begin
      pend_d[iss_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    tr_valid_d = wr_act;
    tr_addr_d  = tr_addr_q;
    tr_data_d  = tr_data_q;
    tr_pc_d    = tr_pc_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_act[j]) begin
        tr_addr_d[j*ADDR_W +: ADDR_W]     = wa[j*ADDR_W +: ADDR_W];
        tr_data_d[j*DATA_W +: DATA_W]     = wd[j*DATA_W +: DATA_W];
        tr_pc_d[j*GRF_PC_W +: GRF_PC_W]   = wpc[j*GRF_PC_W +: GRF_PC_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_q[i] <= '0;
      end
      pend_q     <= '0;
      tr_valid_q <= '0;
      tr_addr_q  <= '0;
      tr_data_q  <= '0;
      tr_pc_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_q[i] <= rf_d[i];
      end
      pend_q     <= pend_d;
      tr_valid_q <= tr_valid_d;
      tr_addr_q  <= tr_addr_d;
      tr_data_q  <= tr_data_d;
      tr_pc_q    <= tr_pc_d;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rf_flat[i*DATA_W +: DATA_W] = rf_q[i];
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    grf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NWR    (NWR),
      .BYPASS (BYPASS)
    ) u_rd (
      .rd_addr  (rd_addr[k*ADDR_W +: ADDR_W]),
      .rf_flat  (rf_flat),
      .pend_vec (pend_q),
      .wr_act   (wr_act),
      .wa       (wa),
      .wd       (wd),
      .rd_data  (rd_data[k*DATA_W +: DATA_W]),
      .rd_pend  (rd_pend[k])
    );
  end

  assign tr_valid = tr_valid_q;
  assign tr_addr  = tr_addr_q;
  assign tr_data  = tr_data_q;
  assign tr_pc    = tr_pc_q;

endmodule

// File: tb/tb_grf_multiport.sv
// Bench for grf_multiport: directed stimulus pushes expected reads/traces, a negedge monitor pops and compares.
module tb_grf_multiport;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic                 clk;
  logic                 reset_n;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*DW-1:0]    rd_data;
  logic [NRD-1:0]       rd_pend;
  logic [NWR-1:0]       we;
  logic [NWR*AW-1:0]    wa;
  logic [NWR*DW-1:0]    wd;
  logic [NWR*32-1:0]    wpc;
  logic                 iss_valid;
  logic [AW-1:0]        iss_addr;
  logic [NWR-1:0]       tr_valid;
  logic [NWR*AW-1:0]    tr_addr;
  logic [NWR*DW-1:0]    tr_data;
  logic [NWR*32-1:0]    tr_pc;

  grf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .we(we), .wa(wa), .wd(wd), .wpc(wpc),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .tr_valid(tr_valid), .tr_addr(tr_addr), .tr_data(tr_data), .tr_pc(tr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int          exp_cyc  [$];
  int          exp_port [$];
  logic [31:0] exp_data [$];
  logic        exp_pend [$];
  logic [68:0] tr_q0 [$];
  logic [68:0] tr_q1 [$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic exp_rd(input int port, input logic [31:0] d, input logic p);
    exp_cyc.push_back(cyc);
    exp_port.push_back(port);
    exp_data.push_back(d);
    exp_pend.push_back(p);
  endtask

  task automatic exp_tr(input int port, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    if (port == 0) tr_q0.push_back({a, d, pc});
    else           tr_q1.push_back({a, d, pc});
  endtask

  task automatic idle();
    we = '0; wa = '0; wd = '0; wpc = '0; iss_valid = 1'b0; iss_addr = '0;
  endtask

  task automatic set_wr(input int j, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    we[j] = 1'b1;
    wa[j*AW +: AW] = a;
    wd[j*DW +: DW] = d;
    wpc[j*32 +: 32] = pc;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Monitor: reads tagged for this cycle and any trace strobe are checked at the falling edge.
  initial begin
    logic [68:0] e;
    int p;
    forever begin
      @(negedge clk);
      while (exp_cyc.size() > 0 && exp_cyc[0] == cyc) begin
        void'(exp_cyc.pop_front());
        p = exp_port.pop_front();
        check($sformatf("rd%0d_cyc%0d", p, cyc), {rd_pend[p], rd_data[p*DW +: DW]},
              {exp_pend.pop_front(), exp_data.pop_front()});
      end
      for (int j = 0; j < NWR; j++) begin
        if (tr_valid[j]) begin
          if ((j == 0 && tr_q0.size() == 0) || (j == 1 && tr_q1.size() == 0)) begin
            check($sformatf("tr%0d_unexpected_cyc%0d", j, cyc), 1'b1, 1'b0);
          end else begin
            e = (j == 0) ? tr_q0.pop_front() : tr_q1.pop_front();
            check($sformatf("tr%0d_cyc%0d", j, cyc),
                  {tr_addr[j*AW +: AW], tr_data[j*DW +: DW], tr_pc[j*32 +: 32]}, e);
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    rd_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step();
      set_rd(5'(2*i), 5'(2*i+1));
      exp_rd(0, 32'h0, 1'b0);
      exp_rd(1, 32'h0, 1'b0);
    end

    // Single write with same-cycle forward, then stored value and trace.
    step(); set_wr(0, 5, 32'hDEADBEEF, 32'h1000); set_rd(5, 6);
    exp_rd(0, 32'hDEADBEEF, 1'b0); exp_rd(1, 32'h0, 1'b0);
    exp_tr(0, 5, 32'hDEADBEEF, 32'h1000);
    step(); exp_rd(0, 32'hDEADBEEF, 1'b0);

    // Both ports hit $7: port 1 wins data and forward, both trace.
    step(); set_wr(0, 7, 32'h11, 32'h2000); set_wr(1, 7, 32'h22, 32'h2004); set_rd(7, 7);
    exp_rd(0, 32'h22, 1'b0); exp_rd(1, 32'h22, 1'b0);
    exp_tr(0, 7, 32'h11, 32'h2000); exp_tr(1, 7, 32'h22, 32'h2004);
    step(); exp_rd(0, 32'h22, 1'b0); exp_rd(1, 32'h22, 1'b0);

    // Write to $0 is dropped and untraced.
    step(); set_wr(0, 0, 32'h1234, 32'h3000); set_rd(0, 0);
    exp_rd(0, 32'h0, 1'b0); exp_rd(1, 32'h0, 1'b0);
    step(); exp_rd(0, 32'h0, 1'b0); exp_rd(1, 32'h0, 1'b0);

    // Scoreboard on $9: set, clear by write, set-wins-over-clear.
    step(); iss_valid = 1'b1; iss_addr = 9; set_rd(9, 5);
    exp_rd(0, 32'h0, 1'b0); exp_rd(1, 32'hDEADBEEF, 1'b0);
    step(); exp_rd(0, 32'h0, 1'b1);
    step(); set_wr(1, 9, 32'h99, 32'h4000); set_rd(9, 9);
    exp_rd(0, 32'h99, 1'b1); exp_rd(1, 32'h99, 1'b1);
    exp_tr(1, 9, 32'h99, 32'h4000);
    step(); exp_rd(0, 32'h99, 1'b0); exp_rd(1, 32'h99, 1'b0);
    step(); iss_valid = 1'b1; iss_addr = 9; set_wr(0, 9, 32'hAA, 32'h4100);
    exp_rd(0, 32'hAA, 1'b0); exp_rd(1, 32'hAA, 1'b0);
    exp_tr(0, 9, 32'hAA, 32'h4100);
    step(); exp_rd(0, 32'hAA, 1'b1); exp_rd(1, 32'hAA, 1'b1);

    // Two different targets at once, each port forwarding its own write.
    step(); set_wr(0, 4, 32'h44, 32'h5000); set_wr(1, 3, 32'h33, 32'h5004); set_rd(3, 4);
    exp_rd(0, 32'h33, 1'b0); exp_rd(1, 32'h44, 1'b0);
    exp_tr(0, 4, 32'h44, 32'h5000); exp_tr(1, 3, 32'h33, 32'h5004);
    step(); set_rd(9, 4); exp_rd(0, 32'hAA, 1'b1); exp_rd(1, 32'h44, 1'b0);

    // Async reset mid-cycle while a trace strobe and a pend bit are live; the trace is lost by design.
    step(); iss_valid = 1'b1; iss_addr = 12; set_wr(0, 5, 32'h55, 32'h6000); set_rd(5, 12);
    exp_rd(0, 32'h55, 1'b0); exp_rd(1, 32'h0, 1'b0);
    step();
    check("pre_rst_tr_valid", tr_valid, 2'b01);
    check("pre_rst_pend", rd_pend, 2'b10);
    check("pre_rst_rd0", rd_data[DW-1:0], 32'h55);
    #1 reset_n = 1'b0;
    #1;
    check("rst_rd_data", rd_data, '0);
    check("rst_rd_pend", rd_pend, '0);
    check("rst_tr_valid", tr_valid, '0);
    check("rst_tr_addr", tr_addr, '0);
    check("rst_tr_data", tr_data, '0);
    check("rst_tr_pc", tr_pc, '0);

    // Write during reset: forwarded combinationally but never committed.
    step(); set_wr(0, 6, 32'h66, 32'h7000); set_rd(6, 5);
    exp_rd(0, 32'h66, 1'b0); exp_rd(1, 32'h0, 1'b0);
    step(); exp_rd(0, 32'h0, 1'b0);
    #2 reset_n = 1'b1;
    step(); set_rd(6, 12); exp_rd(0, 32'h0, 1'b0); exp_rd(1, 32'h0, 1'b0);

    repeat (3) step();
    check("left_rd_exp", exp_cyc.size(), 0);
    check("left_tr0_exp", tr_q0.size(), 0);
    check("left_tr1_exp", tr_q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grf_multiport.md
GRF_MULTIPORT -- requirements
Module: grf_multiport

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; depth is 2**ADDR_W registers.
REQ-003 Parameter NRD, default 2: number of read ports, range 1..4.
REQ-004 Parameter NWR, default 2: number of write ports, range 1..2.
REQ-005 Parameter BYPASS, default 1: 1 enables write-to-read forwarding in the same cycle.
REQ-006 Port list: clk, input, 1 bit, single clock, rising edge.
REQ-007 Port list: reset_n, input, 1 bit, asynchronous active-low reset.
REQ-008 Port list: rd_addr, input, NRD*ADDR_W bits, packed read addresses; port k uses slice k.
REQ-009 Port list: rd_data, output, NRD*DATA_W bits, packed read data.
REQ-010 Port list: rd_pend, output, NRD bits, scoreboard pending flag of each addressed register.
REQ-011 Port list: we, input, NWR bits, write enables.
REQ-012 Port list: wa, input, NWR*ADDR_W bits, write addresses.
REQ-013 Port list: wd, input, NWR*DATA_W bits, write data.
REQ-014 Port list: wpc, input, NWR*32 bits, PC of the writing instruction; used for trace only.
REQ-015 Port list: iss_valid, input, 1 bit, issue of an instruction that will write iss_addr.
REQ-016 Port list: iss_addr, input, ADDR_W bits, destination register being issued.
REQ-017 Port list: tr_valid, output, NWR bits, registered write-trace strobe.
REQ-018 Port list: tr_addr, output, NWR*ADDR_W bits, trace address.
REQ-019 Port list: tr_data, output, NWR*DATA_W bits, trace data.
REQ-020 Port list: tr_pc, output, NWR*32 bits, trace PC.

Function
REQ-021 Register 0 shall always read 0, shall never be written, and shall never be pending.
REQ-022 Writes shall commit at the rising clk edge for every port with we=1 and wa!=0.
REQ-023 If both write ports target the same address in one cycle, port 1 shall win for both the data and the trace; port 0 shall still emit its trace.
REQ-024 Reads shall be combinational: rd_data[k]=RF[rd_addr[k]].
REQ-025 With BYPASS=1, a read whose address matches an active write (wa!=0) shall return that write's wd in the same cycle, with port 1 taking priority.
REQ-026 With BYPASS=0, such a read shall return the old value until the edge.
REQ-027 Scoreboard: iss_valid with iss_addr!=0 shall set pend[iss_addr] at the next edge.
REQ-028 Scoreboard: an active write shall clear pend[wa] at the next edge.
REQ-029 Scoreboard: if set and clear target the same register in one cycle, set shall win.
REQ-030 rd_pend[k] shall be pend[rd_addr[k]] as registered, and shall not be forwarded by a same-cycle write.
REQ-031 The trace shall be registered with one-cycle latency: tr_valid[j] is high for exactly one cycle, in the cycle after an active write on port j.
REQ-032 Writes to address 0 shall produce no trace.
REQ-033 Invalid parameter values shall cause an elaboration-time error.

Reset
REQ-034 reset_n=0 shall asynchronously clear all registers, all pend bits, tr_valid, tr_addr, tr_data and tr_pc to 0.
REQ-035 During reset, rd_data shall be 0, except for bypass data from an active write when BYPASS=1.
REQ-036 During reset, writes and issues shall be ignored.
REQ-037 Release of reset mid-cycle shall take effect at the first rising edge with reset_n=1.

Structure
REQ-038 A shared package shall hold the default DATA_W, ADDR_W and the PC width constant (32).
REQ-039 One sub-module, grf_read_port, shall implement a single read port's mux, bypass compare and pend lookup, and shall be instantiated NRD times.
REQ-040 Storage, scoreboard and trace registers shall live in the top module.

Verification
REQ-041 Reset then read all 32 addresses -> all rd_data=0 and all rd_pend=0.
REQ-042 Port 0 writes 0xDEADBEEF to $5 while rd_addr0=5 -> with BYPASS=1, same cycle rd_data0=0xDEADBEEF; next cycle tr_valid[0]=1, tr_addr=5, tr_pc=wpc.
REQ-043 Both ports write $7 (0x11, then 0x22) in one cycle -> RF[7]=0x22 and two trace strobes occur.
REQ-044 Write 0x1234 to $0 -> rd_data=0 and no trace.
REQ-045 iss_valid with $9 -> rd_pend=1 next cycle; a write to $9 clears it; issue and write of $9 in the same cycle -> stays pending.
REQ-046 Assert reset_n low asynchronously mid-cycle after writes -> outputs clear immediately, before any clock edge.
